// File: rtl/opsum_requant.sv
// Opsum requantizer: reads 32-bit opsums from the GLB, rescales each to int8,
// packs four per word and writes them back through the shared GLB port.
module opsum_requant #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [15:0]       scale,
  input  logic [4:0]        shift,
  input  logic [7:0]        zero_point,
  input  logic              relu_en,
  output logic              done,
  output logic              busy,
  output logic              glb_en,
  output logic [3:0]        glb_we,
  output logic [ADDR_W-1:0] glb_addr,
  output logic [31:0]       glb_wdata,
  input  logic [31:0]       glb_rdata
);

  localparam int unsigned PROD_W = 48;
  localparam int unsigned SUM_W  = PROD_W + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_Q    = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       scale_q, scale_d;
  logic [4:0]        shift_q, shift_d;
  logic [7:0]        zp_q, zp_d;
  logic              relu_q, relu_d;
  logic [31:0]       psum_q, psum_d;
  logic [31:0]       pack_q, pack_d;
  logic [3:0]        mask_q, mask_d;

  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              en_q, en_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [1:0]               lane;
  logic                     last;
  logic signed [31:0]       psum_s;
  logic signed [16:0]       scale_s;
  logic signed [7:0]        zp_s;
  logic signed [PROD_W-1:0] prod, rnd, r_sh, r_rl;
  logic signed [SUM_W-1:0]  s_ext;
  logic [7:0]               y;

  assign lane = idx_q[1:0];
  assign last = (idx_q == (cnt_q - CNT_W'(1)));

  // Rescale: multiply, round-half-up shift, optional ReLU, zero point, saturate
  always_comb begin
    psum_s  = $signed(psum_q);
    scale_s = $signed({1'b0, scale_q});
    zp_s    = $signed(zp_q);
    prod    = PROD_W'(psum_s) * PROD_W'(scale_s);
    rnd     = (shift_q == 5'd0) ? '0 : (PROD_W'(1) <<< (shift_q - 5'd1));
    r_sh    = (prod + rnd) >>> shift_q;
    r_rl    = (relu_q && r_sh[PROD_W-1]) ? '0 : r_sh;
    s_ext   = SUM_W'(r_rl) + SUM_W'(zp_s);
    if (s_ext > SUM_W'(127)) begin
      y = 8'h7F;
    end else if (s_ext < -SUM_W'(128)) begin
      y = 8'h80;
    end else begin
      y = s_ext[7:0];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    scale_d   = scale_q;
    shift_d   = shift_q;
    zp_d      = zp_q;
    relu_d    = relu_q;
    psum_d    = psum_q;
    pack_d    = pack_q;
    mask_d    = mask_q;
    en_d      = 1'b0;
    we_d      = 4'b0000;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d     = num_words;
          scale_d   = scale;
          shift_d   = shift;
          zp_d      = zero_point;
          relu_d    = relu_en;
          rd_addr_d = src_addr;
          wr_addr_d = dst_addr;
          if (num_words == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = '0;
            pack_d  = '0;
            mask_d  = '0;
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        psum_d  = glb_rdata;
        state_d = S_Q;
      end
      S_Q: begin
        pack_d[{lane, 3'b000} +: 8] = y;
        mask_d[lane] = 1'b1;
        idx_d     = idx_q + CNT_W'(1);
        rd_addr_d = rd_addr_q + ADDR_W'(4);
        state_d   = (lane == 2'd3 || last) ? S_WR : S_RD;
      end
      S_WR: begin
        pack_d    = '0;
        mask_d    = '0;
        wr_addr_d = wr_addr_q + ADDR_W'(4);
        state_d   = (idx_q != cnt_q) ? S_RD : S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // GLB strobes are registered from the state being entered
    if (state_d == S_RD) begin
      en_d   = 1'b1;
      addr_d = rd_addr_d;
    end else if (state_d == S_WR) begin
      en_d    = 1'b1;
      we_d    = mask_d;
      addr_d  = wr_addr_q;
      wdata_d = pack_d;
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      scale_q   <= '0;
      shift_q   <= '0;
      zp_q      <= '0;
      relu_q    <= 1'b0;
      psum_q    <= '0;
      pack_q    <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      scale_q   <= scale_d;
      shift_q   <= shift_d;
      zp_q      <= zp_d;
      relu_q    <= relu_d;
      psum_q    <= psum_d;
      pack_q    <= pack_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign glb_en    = en_q;
  assign glb_we    = we_q;
  assign glb_addr  = addr_q;
  assign glb_wdata = wdata_q;

endmodule

// File: tb/tb_opsum_requant.sv
// Directed bench for opsum_requant with a behavioural GLB (1-cycle read latency).
module tb_opsum_requant;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] num_words;
  logic [15:0] scale;
  logic [4:0]  shift;
  logic [7:0]  zero_point;
  logic        relu_en;
  logic        done;
  logic        busy;
  logic        glb_en;
  logic [3:0]  glb_we;
  logic [31:0] glb_addr;
  logic [31:0] glb_wdata;
  logic [31:0] glb_rdata;

  opsum_requant #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .num_words(num_words),
    .scale(scale), .shift(shift), .zero_point(zero_point), .relu_en(relu_en),
    .done(done), .busy(busy),
    .glb_en(glb_en), .glb_we(glb_we), .glb_addr(glb_addr),
    .glb_wdata(glb_wdata), .glb_rdata(glb_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit [31:0] src_mem [0:63];
  bit [7:0]  dst_mem [0:511];
  bit [31:0] wr_addr_log [0:15];
  bit [31:0] wr_data_log [0:15];
  bit [3:0]  wr_we_log   [0:15];
  int        cyc, done_cnt, done_cyc, wr_cnt, en_cnt;
  int        start_cyc;
  logic      fill;
  int        n_tests, n_fail;

  // GLB model and event monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fill) begin
      for (int a = 0; a < 512; a++) dst_mem[a] <= 8'hAA;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc - start_cyc;
    end
    if (!rst && glb_en) begin
      en_cnt <= en_cnt + 1;
      if (glb_we == 4'b0000) begin
        glb_rdata <= src_mem[glb_addr[7:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (glb_we[b]) dst_mem[glb_addr[8:0] + 9'(b)] <= glb_wdata[8*b +: 8];
        end
        wr_addr_log[wr_cnt[3:0]] <= glb_addr;
        wr_data_log[wr_cnt[3:0]] <= glb_wdata;
        wr_we_log[wr_cnt[3:0]]   <= glb_we;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] n, input logic [15:0] sc,
                           input logic [4:0] sh, input logic [7:0] zp, input logic re);
    @(negedge clk);
    src_addr = src; dst_addr = dst; num_words = n;
    scale = sc; shift = sh; zero_point = zp; relu_en = re;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    src_addr = 32'h3C; dst_addr = 32'h1F0; num_words = 16'd9;
    scale = 16'd77; shift = 5'd7; zero_point = 8'h55; relu_en = ~re;
  endtask

  // Bounded wait for done, then a few idle cycles; checks exactly one pulse
  task automatic wait_done(input string tag, input int base);
    int k;
    k = 0;
    while (done_cnt == base && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk(tag, 32'(done_cnt - base), 32'd1);
  endtask

  int bd, bw, be;

  initial begin
    n_tests = 0; n_fail = 0; start_cyc = 0; fill = 1'b0;
    rst = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; num_words = '0; scale = '0;
    shift = '0; zero_point = '0; relu_en = 1'b0;
    src_mem[0] = 32'd100;  src_mem[1] = -32'sd100; src_mem[2] = 32'd0; src_mem[3] = 32'd1;
    src_mem[4] = 32'd1000000; src_mem[5] = -32'sd1000000;
    src_mem[8] = 32'd1; src_mem[9] = 32'd2; src_mem[10] = 32'd3; src_mem[11] = 32'd4;
    src_mem[12] = -32'sd1;

    repeat (3) @(negedge clk);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_en", {31'b0, glb_en}, 32'd0);
    chk("rst_we", {28'b0, glb_we}, 32'd0);
    chk("rst_addr", glb_addr, 32'd0);
    chk("rst_wdata", glb_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic pack
    bd = done_cnt; bw = wr_cnt; be = en_cnt;
    start_job(32'h0, 32'h100, 16'd4, 16'd3, 5'd2, 8'h00, 1'b0);
    chk("t1_busy_c1", {31'b0, busy}, 32'd1);
    wait_done("t1_done_pulses", bd);
    chk("t1_done_cyc", 32'(done_cyc), 32'd14);
    chk("t1_nwr", 32'(wr_cnt - bw), 32'd1);
    chk("t1_nen", 32'(en_cnt - be), 32'd5);
    chk("t1_addr", wr_addr_log[4'(bw)], 32'h100);
    chk("t1_data", wr_data_log[4'(bw)], 32'h0100B54B);
    chk("t1_we", {28'b0, wr_we_log[4'(bw)]}, 32'hF);
    chk("t1_busy_end", {31'b0, busy}, 32'd0);

    // ReLU and zero point
    bd = done_cnt; bw = wr_cnt;
    start_job(32'h0, 32'h120, 16'd4, 16'd3, 5'd2, 8'hFB, 1'b1);
    wait_done("t2_done_pulses", bd);
    chk("t2_addr", wr_addr_log[4'(bw)], 32'h120);
    chk("t2_data", wr_data_log[4'(bw)], 32'hFCFBFB46);

    // Saturation both ways
    bd = done_cnt; bw = wr_cnt;
    start_job(32'h10, 32'h140, 16'd2, 16'd1, 5'd0, 8'h00, 1'b0);
    wait_done("t3_done_pulses", bd);
    chk("t3_done_cyc", 32'(done_cyc), 32'd8);
    chk("t3_nwr", 32'(wr_cnt - bw), 32'd1);
    chk("t3_data", wr_data_log[4'(bw)], 32'h0000807F);
    chk("t3_we", {28'b0, wr_we_log[4'(bw)]}, 32'h3);

    // Partial tail over a pre-filled destination
    @(negedge clk); fill = 1'b1;
    @(negedge clk); fill = 1'b0;
    bd = done_cnt; bw = wr_cnt;
    start_job(32'h20, 32'h100, 16'd5, 16'd1, 5'd0, 8'h00, 1'b0);
    wait_done("t4_done_pulses", bd);
    chk("t4_done_cyc", 32'(done_cyc), 32'd18);
    chk("t4_nwr", 32'(wr_cnt - bw), 32'd2);
    chk("t4_addr0", wr_addr_log[4'(bw)], 32'h100);
    chk("t4_data0", wr_data_log[4'(bw)], 32'h04030201);
    chk("t4_we0", {28'b0, wr_we_log[4'(bw)]}, 32'hF);
    chk("t4_addr1", wr_addr_log[4'(bw + 1)], 32'h104);
    chk("t4_data1", wr_data_log[4'(bw + 1)], 32'h000000FF);
    chk("t4_we1", {28'b0, wr_we_log[4'(bw + 1)]}, 32'h1);
    chk("t4_mem", {dst_mem[9'h107], dst_mem[9'h106], dst_mem[9'h105], dst_mem[9'h104]},
        32'hAAAAAAFF);

    // Zero count
    bd = done_cnt; be = en_cnt;
    start_job(32'h0, 32'h180, 16'd0, 16'd3, 5'd2, 8'h00, 1'b0);
    wait_done("t5_done_pulses", bd);
    chk("t5_done_cyc", 32'(done_cyc), 32'd1);
    chk("t5_nen", 32'(en_cnt - be), 32'd0);

    // Start while busy is ignored
    bd = done_cnt; bw = wr_cnt;
    start_job(32'h0, 32'h160, 16'd4, 16'd3, 5'd2, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    num_words = 16'd1; dst_addr = 32'h1C0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6_done_pulses", bd);
    chk("t6_done_cyc", 32'(done_cyc), 32'd14);
    chk("t6_nwr", 32'(wr_cnt - bw), 32'd1);
    chk("t6_addr", wr_addr_log[4'(bw)], 32'h160);
    chk("t6_data", wr_data_log[4'(bw)], 32'h0100B54B);

    // Reset in cycle 7 of a run
    bd = done_cnt; bw = wr_cnt;
    start_job(32'h0, 32'h180, 16'd4, 16'd3, 5'd2, 8'h00, 1'b0);
    repeat (6) @(negedge clk);
    chk("t7_en_before", {31'b0, glb_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t7_en", {31'b0, glb_en}, 32'd0);
    chk("t7_busy", {31'b0, busy}, 32'd0);
    chk("t7_addr", glb_addr, 32'd0);
    chk("t7_we", {28'b0, glb_we}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t7_nwr", 32'(wr_cnt - bw), 32'd0);
    chk("t7_ndone", 32'(done_cnt - bd), 32'd0);
    bd = done_cnt; bw = wr_cnt;
    start_job(32'h0, 32'h180, 16'd4, 16'd3, 5'd2, 8'h00, 1'b0);
    wait_done("t7_done_pulses", bd);
    chk("t7_done_cyc", 32'(done_cyc), 32'd14);
    chk("t7_data", wr_data_log[4'(bw)], 32'h0100B54B);
    chk("t7_waddr", wr_addr_log[4'(bw)], 32'h180);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
